// File: rtl/fighter_pkg.sv
// Shared types and constants for the per-player fighter controller:
// action states, hit_flag codes, sprite/box geometry and the neutral decode.
package fighter_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_FWD       = 4'd1,
    ST_BACK      = 4'd2,
    ST_B_START   = 4'd3,
    ST_B_ACT     = 4'd4,
    ST_B_REC     = 4'd5,
    ST_D_START   = 4'd6,
    ST_D_ACT     = 4'd7,
    ST_D_REC     = 4'd8,
    ST_HITSTUN   = 4'd9,
    ST_BLOCKSTUN = 4'd10
  } state_e;

  localparam logic [1:0] HIT_NONE  = 2'b00;
  localparam logic [1:0] HIT_BASIC = 2'b01;
  localparam logic [1:0] HIT_DIR   = 2'b10;

  localparam int SPRITE_W = 113;

  localparam int BB_X_LO = 35;
  localparam int BB_X_HI = 113;
  localparam int BB_Y_LO = 24;
  localparam int BB_Y_HI = 57;
  localparam int DB_X_LO = 62;
  localparam int DB_X_HI = 95;
  localparam int DB_Y_LO = 6;
  localparam int DB_Y_HI = 110;
  localparam int HB_X_LO = 28;
  localparam int HB_X_HI = 81;
  localparam int HB_Y_LO = 0;
  localparam int HB_Y_HI = 150;

  // Both inputs together mean back; side=1 mirrors which input points at the opponent.
  function automatic state_e dir_next(input logic left, input logic right, input logic side);
    state_e nxt;
    if (left && right) begin
      nxt = ST_BACK;
    end else if (right) begin
      nxt = side ? ST_BACK : ST_FWD;
    end else if (left) begin
      nxt = side ? ST_FWD : ST_BACK;
    end else begin
      nxt = ST_IDLE;
    end
    return nxt;
  endfunction

  function automatic state_e neutral_next(input logic attack, input logic left,
                                          input logic right, input logic side);
    state_e nxt;
    if (attack) begin
      nxt = ST_B_START;
    end else begin
      nxt = dir_next(left, right, side);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/fighter_frame_timer.sv
// Per-state frame down-counter: loads on a tick, counts down on ticks, stops at zero.
module fighter_frame_timer
  import fighter_pkg::*;
#(
  parameter int TMR_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  output logic [TMR_W-1:0] count_o,
  output logic             zero_o
);

  logic [TMR_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (tick_i && load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != {TMR_W{1'b0}})) begin
      count_d = count_q - TMR_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {TMR_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == {TMR_W{1'b0}});

endmodule

// File: rtl/fighter_fsm.sv
// One fighter's action FSM, saturating position and hit/hurt boxes, stepped by frame_tick_i.
// Optional INPUT_BUFFER_EN: remembers an attack pressed during recovery/stun for the exit tick.
module fighter_fsm
  import fighter_pkg::*;
#(
  parameter int SIDE      = 0,
  parameter int X_W       = 10,
  parameter int START_X   = 100,
  parameter int X_MIN     = 10,
  parameter int X_MAX     = 517,
  parameter int POS_Y     = 170,
  parameter int SPD_FWD   = 3,
  parameter int SPD_BACK  = 2,
  parameter int B_STARTUP = 5,
  parameter int B_ACTIVE  = 2,
  parameter int B_RECOVER = 16,
  parameter int D_STARTUP = 4,
  parameter int D_ACTIVE  = 3,
  parameter int D_RECOVER = 15,
  parameter int HS_B      = 15,
  parameter int HS_D      = 14,
  parameter int BS_B      = 13,
  parameter int BS_D      = 12,
  parameter int TMR_W     = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick_i,
  input  logic               left_i,
  input  logic               right_i,
  input  logic               attack_i,
  input  logic [1:0]         hit_flag_i,
  input  logic               block_ok_i,
  output logic [3:0]         state_o,
  output logic [TMR_W-1:0]   timer_o,
  output logic [X_W-1:0]     posx_o,
  output logic [X_W-1:0]     posy_o,
  output logic               basic_active_o,
  output logic               dir_active_o,
  output logic               hurt_pulse_o,
  output logic               block_pulse_o,
  output logic [4*X_W-1:0]   box_b_o,
  output logic [4*X_W-1:0]   box_d_o,
  output logic [4*X_W-1:0]   box_h_o
);

  localparam logic           SIDE_B  = (SIDE != 0);
  localparam logic [X_W:0]   X_MIN_E = (X_W+1)'(X_MIN);
  localparam logic [X_W:0]   X_MAX_E = (X_W+1)'(X_MAX);

  state_e             state_q, state_d;
  logic [X_W-1:0]     posx_q, posx_d;
  logic               basic_act_q, dir_act_q, hurt_pulse_q, block_pulse_q;
  logic               stun_s, hit_s, hit_dir_s, atk_neutral_s;
  logic               load_s, tmr_zero_s;
  logic [TMR_W-1:0]   load_val_s, tmr_cnt_s;

  // A zero duration still occupies one tick.
  function automatic logic [TMR_W-1:0] dur_m1(input int d);
    return (d > 0) ? TMR_W'(d - 1) : {TMR_W{1'b0}};
  endfunction

  function automatic logic [X_W-1:0] sat_add(input logic [X_W-1:0] p, input int spd);
    logic [X_W:0] s;
    s = {1'b0, p} + (X_W+1)'(spd);
    return (s > X_MAX_E) ? X_MAX_E[X_W-1:0] : s[X_W-1:0];
  endfunction

  function automatic logic [X_W-1:0] sat_sub(input logic [X_W-1:0] p, input int spd);
    logic [X_W:0] s;
    s = {1'b0, p} - (X_W+1)'(spd);
    return ({1'b0, p} < (X_MIN_E + (X_W+1)'(spd))) ? X_MIN_E[X_W-1:0] : s[X_W-1:0];
  endfunction

  function automatic logic [4*X_W-1:0] mk_box(input logic [X_W-1:0] px, input int xl,
                                              input int xh, input int yl, input int yh);
    logic [X_W-1:0] x1, x2, y1, y2;
    if (SIDE_B) begin
      x1 = px + X_W'(SPRITE_W - xh);
      x2 = px + X_W'(SPRITE_W - xl);
    end else begin
      x1 = px + X_W'(xl);
      x2 = px + X_W'(xh);
    end
    y1 = X_W'(POS_Y + yl);
    y2 = X_W'(POS_Y + yh);
    return {x1, x2, y1, y2};
  endfunction

`ifdef INPUT_BUFFER_EN
  logic buf_q, buf_d;

  always_comb begin
    buf_d = buf_q;
    if (!frame_tick_i) begin
      buf_d = buf_q;
    end else if (hit_s) begin
      buf_d = 1'b0;
    end else if (state_q == ST_B_REC || state_q == ST_D_REC || stun_s) begin
      buf_d = tmr_zero_s ? 1'b0 : (buf_q | attack_i);
    end else begin
      buf_d = buf_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_q <= 1'b0;
    end else begin
      buf_q <= buf_d;
    end
  end

  assign atk_neutral_s = attack_i | buf_q;
`else
  assign atk_neutral_s = attack_i;
`endif

  assign stun_s    = (state_q == ST_HITSTUN) || (state_q == ST_BLOCKSTUN);
  assign hit_s     = frame_tick_i && (hit_flag_i != HIT_NONE) && !stun_s;
  assign hit_dir_s = (hit_flag_i == HIT_DIR);

  always_comb begin
    state_d    = state_q;
    load_val_s = {TMR_W{1'b0}};
    if (!frame_tick_i) begin
      state_d = state_q;
    end else if (hit_s) begin
      state_d = (state_q == ST_BACK && block_ok_i) ? ST_BLOCKSTUN : ST_HITSTUN;
    end else begin
      case (state_q)
        ST_IDLE:          state_d = neutral_next(attack_i, left_i, right_i, SIDE_B);
        ST_FWD, ST_BACK:  state_d = attack_i ? ST_D_START : dir_next(left_i, right_i, SIDE_B);
        ST_B_START:       state_d = tmr_zero_s ? ST_B_ACT : ST_B_START;
        ST_B_ACT:         state_d = tmr_zero_s ? ST_B_REC : ST_B_ACT;
        ST_D_START:       state_d = tmr_zero_s ? ST_D_ACT : ST_D_START;
        ST_D_ACT:         state_d = tmr_zero_s ? ST_D_REC : ST_D_ACT;
        ST_B_REC, ST_D_REC, ST_HITSTUN, ST_BLOCKSTUN:
          state_d = tmr_zero_s ? neutral_next(atk_neutral_s, left_i, right_i, SIDE_B) : state_q;
        default:          state_d = ST_IDLE;
      endcase
    end
    // Untimed states load zero so their timer stays parked at 0.
    case (state_d)
      ST_B_START:   load_val_s = dur_m1(B_STARTUP);
      ST_B_ACT:     load_val_s = dur_m1(B_ACTIVE);
      ST_B_REC:     load_val_s = dur_m1(B_RECOVER);
      ST_D_START:   load_val_s = dur_m1(D_STARTUP);
      ST_D_ACT:     load_val_s = dur_m1(D_ACTIVE);
      ST_D_REC:     load_val_s = dur_m1(D_RECOVER);
      ST_HITSTUN:   load_val_s = hit_dir_s ? dur_m1(HS_D) : dur_m1(HS_B);
      ST_BLOCKSTUN: load_val_s = hit_dir_s ? dur_m1(BS_D) : dur_m1(BS_B);
      default:      load_val_s = {TMR_W{1'b0}};
    endcase
  end

  assign load_s = frame_tick_i && (state_d != state_q);

  fighter_frame_timer #(.TMR_W(TMR_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .tick_i     (frame_tick_i),
    .load_i     (load_s),
    .load_val_i (load_val_s),
    .count_o    (tmr_cnt_s),
    .zero_o     (tmr_zero_s)
  );

  // Movement uses the state held before this tick's transition.
  always_comb begin
    posx_d = posx_q;
    if (frame_tick_i && state_q == ST_FWD) begin
      posx_d = SIDE_B ? sat_sub(posx_q, SPD_FWD) : sat_add(posx_q, SPD_FWD);
    end else if (frame_tick_i && state_q == ST_BACK) begin
      posx_d = SIDE_B ? sat_add(posx_q, SPD_BACK) : sat_sub(posx_q, SPD_BACK);
    end else begin
      posx_d = posx_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      posx_q        <= X_W'(START_X);
      basic_act_q   <= 1'b0;
      dir_act_q     <= 1'b0;
      hurt_pulse_q  <= 1'b0;
      block_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      posx_q        <= posx_d;
      basic_act_q   <= (state_d == ST_B_ACT);
      dir_act_q     <= (state_d == ST_D_ACT);
      hurt_pulse_q  <= frame_tick_i && (state_d == ST_HITSTUN) && (state_q != ST_HITSTUN);
      block_pulse_q <= frame_tick_i && (state_d == ST_BLOCKSTUN) && (state_q != ST_BLOCKSTUN);
    end
  end

  assign state_o        = state_q;
  assign timer_o        = tmr_cnt_s;
  assign posx_o         = posx_q;
  assign posy_o         = X_W'(POS_Y);
  assign basic_active_o = basic_act_q;
  assign dir_active_o   = dir_act_q;
  assign hurt_pulse_o   = hurt_pulse_q;
  assign block_pulse_o  = block_pulse_q;
  assign box_b_o        = mk_box(posx_q, BB_X_LO, BB_X_HI, BB_Y_LO, BB_Y_HI);
  assign box_d_o        = mk_box(posx_q, DB_X_LO, DB_X_HI, DB_Y_LO, DB_Y_HI);
  assign box_h_o        = mk_box(posx_q, HB_X_LO, HB_X_HI, HB_Y_LO, HB_Y_HI);

endmodule
